// File: rtl/ahb_bridge_arbiter.sv
// ahb_bridge_arbiter: round-robin two-requester arbiter that sequences single
// non-pipelined AHB transfers into the bridge and returns status/read data.
module ahb_bridge_arbiter #(
    parameter int          TIMEOUT = 16,
    parameter logic [31:0] ADDR_LO = 32'h8000_0000,
    parameter logic [31:0] ADDR_HI = 32'h8C00_0000
) (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic        req0,
    input  logic [31:0] addr0,
    input  logic        write0,
    input  logic [31:0] wdata0,
    output logic        ack0,
    output logic        err0,
    output logic [31:0] rdata0,
    input  logic        req1,
    input  logic [31:0] addr1,
    input  logic        write1,
    input  logic [31:0] wdata1,
    output logic        ack1,
    output logic        err1,
    output logic [31:0] rdata1,
    output logic [1:0]  grant,
    output logic [31:0] Haddr,
    output logic        Hwrite,
    output logic [31:0] Hwdata,
    output logic [1:0]  Htrans,
    output logic        Hreadyin,
    input  logic        Hreadyout,
    input  logic [1:0]  Hresp,
    input  logic [31:0] Hrdata
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, REJ} state_t;

    state_t        state, state_n;
    logic          last, last_n, win, win_n, pick, sel_write, in_range, done, expired;
    logic          hwrite_n, hreadyin_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    grant_n, htrans_n, ack, ack_n, err, err_n;
    logic [31:0]   wd, wd_n, haddr_n, hwdata_n, rd0_n, rd1_n, sel_addr, sel_wdata;

    assign pick      = (req0 && req1) ? ~last : req1;
    assign sel_addr  = pick ? addr1 : addr0;
    assign sel_write = pick ? write1 : write0;
    assign sel_wdata = pick ? wdata1 : wdata0;
    assign in_range  = sel_addr >= ADDR_LO && sel_addr < ADDR_HI;
    // the bridge's ready in the first DATA cycle still belongs to the address phase
    assign done      = cnt != '0 && Hreadyout;
    assign expired   = cnt == CW'(TIMEOUT - 1);
    assign {ack1, ack0} = ack;
    assign {err1, err0} = err;

    always_comb begin
        state_n    = state;
        last_n     = last;
        win_n      = win;
        cnt_n      = '0;
        grant_n    = grant;
        haddr_n    = Haddr;
        hwrite_n   = Hwrite;
        hwdata_n   = Hwdata;
        wd_n       = wd;
        htrans_n   = 2'b00;
        hreadyin_n = 1'b0;
        ack_n      = 2'b00;
        err_n      = 2'b00;
        rd0_n      = rdata0;
        rd1_n      = rdata1;
        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    win_n   = pick;
                    last_n  = pick;
                    grant_n = pick ? 2'b10 : 2'b01;
                    if (in_range) begin
                        state_n    = ADDR;
                        haddr_n    = sel_addr;
                        hwrite_n   = sel_write;
                        wd_n       = sel_wdata;
                        htrans_n   = 2'b10;
                        hreadyin_n = 1'b1;
                    end else begin
                        state_n     = REJ;
                        ack_n[pick] = 1'b1;
                        err_n[pick] = 1'b1;
                    end
                end
            end
            ADDR: begin
                state_n    = DATA;
                hreadyin_n = 1'b1;
                hwdata_n   = wd;
            end
            DATA: begin
                cnt_n      = cnt + CW'(1);
                hreadyin_n = 1'b1;
                if (done || expired) begin
                    state_n    = DONE;
                    cnt_n      = '0;
                    hreadyin_n = 1'b0;
                    grant_n    = 2'b00;
                    ack_n[win] = 1'b1;
                    err_n[win] = done ? |Hresp : 1'b1;
                    rd0_n      = (done && !Hwrite && !win) ? Hrdata : rdata0;
                    rd1_n      = (done && !Hwrite && win) ? Hrdata : rdata1;
                end
            end
            DONE, REJ: begin
                state_n = IDLE;
                grant_n = 2'b00;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state    <= IDLE;
            last     <= 1'b1;
            win      <= 1'b0;
            cnt      <= '0;
            grant    <= 2'b00;
            Haddr    <= '0;
            Hwrite   <= 1'b0;
            Hwdata   <= '0;
            wd       <= '0;
            Htrans   <= 2'b00;
            Hreadyin <= 1'b0;
            ack      <= 2'b00;
            err      <= 2'b00;
            rdata0   <= '0;
            rdata1   <= '0;
        end else begin
            state    <= state_n;
            last     <= last_n;
            win      <= win_n;
            cnt      <= cnt_n;
            grant    <= grant_n;
            Haddr    <= haddr_n;
            Hwrite   <= hwrite_n;
            Hwdata   <= hwdata_n;
            wd       <= wd_n;
            Htrans   <= htrans_n;
            Hreadyin <= hreadyin_n;
            ack      <= ack_n;
            err      <= err_n;
            rdata0   <= rd0_n;
            rdata1   <= rd1_n;
        end
    end

    // an owner must keep requesting until it sees its ack
    a_req_held: assert property (@(posedge Hclk) disable iff (Hreset)
        (state == ADDR || state == DATA) |-> (win ? req1 : req0));
    a_grant_onehot0: assert property (@(posedge Hclk) disable iff (Hreset) $onehot0(grant));
endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// tb_ahb_bridge_arbiter: vector table plus contention/reset sequences against a
// bridge model, with expected acks queued at drive time and checked on arrival.
module tb_ahb_bridge_arbiter;
    logic        Hclk = 1'b0, Hreset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, write0 = 1'b0, write1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, err0, err1, Hwrite, Hreadyin;
    logic [31:0] rdata0, rdata1, Haddr, Hwdata;
    logic [1:0]  grant, Htrans;
    logic        Hreadyout = 1'b0;
    logic [1:0]  Hresp = 2'b00;
    logic [31:0] Hrdata = '0;

    ahb_bridge_arbiter dut (
        .Hclk(Hclk), .Hreset(Hreset),
        .req0(req0), .addr0(addr0), .write0(write0), .wdata0(wdata0),
        .ack0(ack0), .err0(err0), .rdata0(rdata0),
        .req1(req1), .addr1(addr1), .write1(write1), .wdata1(wdata1),
        .ack1(ack1), .err1(err1), .rdata1(rdata1),
        .grant(grant), .Haddr(Haddr), .Hwrite(Hwrite), .Hwdata(Hwdata),
        .Htrans(Htrans), .Hreadyin(Hreadyin), .Hreadyout(Hreadyout),
        .Hresp(Hresp), .Hrdata(Hrdata)
    );

    always #5 Hclk = ~Hclk;

    typedef struct {
        logic        p;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [1:0]  resp;
        logic        hang;
        logic        early;
        logic        e_err;
        int          lat;
    } vec_t;

    typedef struct {
        logic        p;
        logic        err;
        logic        upd;
        logic [31:0] rd;
        int          start;
        int          lat;
    } exp_t;

    int          pass_n = 0, tot_n = 0, cyc = 0, ph = 99, n;
    logic        hang = 1'b0, early = 1'b0, busy_seen = 1'b0, prev_ack = 1'b0, mg;
    logic [1:0]  resp_k = 2'b00, prev_grant = 2'b00;
    logic [31:0] rd_k = '0;
    logic [31:0] d_addr[2], d_wd[2], exp_rd[2];
    logic        d_wr[2];
    logic [1:0]  glog[$];
    exp_t        sbq[$];
    exp_t        me;
    vec_t        vt[9];
    logic        any_out;

    assign any_out = |{ack0, ack1, err0, err1, rdata0, rdata1, grant, Haddr, Hwrite,
                       Hwdata, Htrans, Hreadyin};

    function automatic logic in_rng(input logic [31:0] a);
        return a >= 32'h8000_0000 && a < 32'h8C00_0000;
    endfunction

    function automatic vec_t mk(input logic p, input logic [31:0] a, input logic w,
                                input logic [31:0] wd, input logic [31:0] rd,
                                input logic [1:0] rs, input logic hg, input logic er,
                                input logic ee, input int lat);
        vec_t v;
        v.p = p; v.addr = a; v.wr = w; v.wd = wd; v.rd = rd; v.resp = rs;
        v.hang = hg; v.early = er; v.e_err = ee; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_exp(input logic p, input logic e, input logic upd,
                            input logic [31:0] rd, input int lat);
        exp_t x;
        x.p = p; x.err = e; x.upd = upd; x.rd = rd; x.start = cyc; x.lat = lat;
        sbq.push_back(x);
    endtask

    task automatic wait_ack(input logic p, input int lim);
        logic got;
        got = 1'b0;
        for (int i = 0; i < lim && !got; i++) begin
            @(negedge Hclk);
            got = p ? ack1 : ack0;
        end
        if (!got) begin
            tot_n++;
            $display("FAIL ack_wait: no ack%0d within %0d cycles", p, lim);
        end
    endtask

    task automatic wait_acks(input int want, input int lim);
        n = 0;
        for (int i = 0; i < lim && n < want; i++) begin
            @(negedge Hclk);
            if (ack0 || ack1) n++;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        chk("ack_count", n, want);
    endtask

    task automatic run(input vec_t v);
        int st;
        @(negedge Hclk);
        hang = v.hang; early = v.early; resp_k = v.resp; rd_k = v.rd;
        d_addr[v.p] = v.addr; d_wr[v.p] = v.wr; d_wd[v.p] = v.wd;
        push_exp(v.p, v.e_err, in_rng(v.addr) && !v.wr && !v.hang, v.rd, v.lat);
        busy_seen = 1'b0;
        st = cyc;
        if (v.p) begin addr1 = v.addr; write1 = v.wr; wdata1 = v.wd; req1 = 1'b1; end
        else begin addr0 = v.addr; write0 = v.wr; wdata0 = v.wd; req0 = 1'b1; end
        wait_ack(v.p, 40);
        req0 = 1'b0;
        req1 = 1'b0;
        if (!in_rng(v.addr)) begin
            chk("rej_no_bus", busy_seen, 0);
            chk("rej_latency_le2", (cyc - st) <= 2, 1);
        end
    endtask

    initial forever begin
        @(posedge Hclk);
        cyc++;
    end

    // bridge model: read ready at ADDR+2, write ready at ADDR+3, optional stray ready at ADDR+1
    initial forever begin
        @(negedge Hclk);
        if (Htrans == 2'b10) ph = 0;
        else if (ph < 99) ph++;
        Hreadyout = (ph == 1 && early) || (!hang && ph == (Hwrite ? 3 : 2));
        Hresp     = Hreadyout ? resp_k : 2'b00;
        Hrdata    = rd_k;
    end

    initial forever begin
        @(negedge Hclk);
        if (!Hreset) begin
            chk("grant_onehot0", $onehot0(grant), 1);
            chk("ack_exclusive", ack0 & ack1, 0);
            if (Htrans != 2'b00 || Hreadyin) busy_seen = 1'b1;
            if (prev_ack) chk("idle_after_ack", {grant, Htrans, Hreadyin}, 0);
            if (Hreadyin) begin
                mg = grant[1];
                chk("haddr", Haddr, d_addr[mg]);
                chk("hwrite", Hwrite, d_wr[mg]);
                if (Htrans == 2'b00 && Hwrite) chk("hwdata", Hwdata, d_wd[mg]);
            end
            if (grant != 2'b00 && prev_grant == 2'b00) glog.push_back(grant);
            if (ack0 || ack1) begin
                if (sbq.size() == 0) begin
                    tot_n++;
                    $display("FAIL unexpected_ack: ack0=%0b ack1=%0b with none pending", ack0, ack1);
                end else begin
                    me = sbq.pop_front();
                    chk("ack_port", ack1, me.p);
                    chk("ack_err", ack1 ? err1 : err0, me.err);
                    if (me.upd) exp_rd[me.p] = me.rd;
                    chk("rdata0", rdata0, exp_rd[0]);
                    chk("rdata1", rdata1, exp_rd[1]);
                    if (me.lat >= 0) chk("latency", cyc - me.start, me.lat);
                end
            end
            prev_ack   = ack0 | ack1;
            prev_grant = grant;
        end else begin
            prev_ack   = 1'b0;
            prev_grant = 2'b00;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            d_addr[i] = '0; d_wd[i] = '0; d_wr[i] = 1'b0; exp_rd[i] = '0;
        end
        vt[0] = mk(1'b0, 32'h8000_0010, 1'b0, 32'h0,         32'hDEAD_BEEF, 2'b00, 1'b0, 1'b0, 1'b0, 4);
        vt[1] = mk(1'b1, 32'h8400_0004, 1'b1, 32'h1234_5678, 32'h0BAD_0BAD, 2'b00, 1'b0, 1'b1, 1'b0, 5);
        vt[2] = mk(1'b0, 32'h8C00_0000, 1'b0, 32'h0,         32'h1111_1111, 2'b00, 1'b0, 1'b0, 1'b1, -1);
        vt[3] = mk(1'b0, 32'h7FFF_FFFC, 1'b1, 32'h2222_2222, 32'h1111_1111, 2'b00, 1'b0, 1'b0, 1'b1, -1);
        vt[4] = mk(1'b0, 32'h8000_0020, 1'b0, 32'h0,         32'h5555_5555, 2'b00, 1'b1, 1'b0, 1'b1, 18);
        vt[5] = mk(1'b1, 32'h8BFF_FFFC, 1'b0, 32'h0,         32'hCAFE_F00D, 2'b01, 1'b0, 1'b0, 1'b1, 4);
        vt[6] = mk(1'b0, 32'h8000_0000, 1'b1, 32'hA0A0_A0A0, 32'h0,         2'b00, 1'b0, 1'b1, 1'b0, 5);
        vt[7] = mk(1'b1, 32'h8400_0008, 1'b1, 32'h0F0F_0F0F, 32'h0,         2'b10, 1'b0, 1'b0, 1'b1, 5);
        vt[8] = mk(1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0,         32'h0,         2'b00, 1'b0, 1'b0, 1'b1, -1);

        repeat (2) @(negedge Hclk);
        chk("reset_outputs_zero", any_out, 0);
        chk("reset_grant", grant, 0);
        Hreset = 1'b0;

        for (int i = 0; i < 9; i++) run(vt[i]);

        // both requesters held: ownership alternates starting with requester 0
        @(negedge Hclk);
        hang = 1'b0; early = 1'b0; resp_k = 2'b00; rd_k = 32'hA5A5_0001;
        d_addr[0] = 32'h8000_0100; d_wr[0] = 1'b0;
        d_addr[1] = 32'h8400_0200; d_wr[1] = 1'b0;
        addr0 = d_addr[0]; write0 = 1'b0; addr1 = d_addr[1]; write1 = 1'b0;
        push_exp(1'b0, 1'b0, 1'b1, rd_k, -1);
        push_exp(1'b1, 1'b0, 1'b1, rd_k, -1);
        push_exp(1'b0, 1'b0, 1'b1, rd_k, -1);
        glog.delete();
        req0 = 1'b1;
        req1 = 1'b1;
        wait_acks(3, 60);
        chk("grant_seq_len", glog.size(), 3);
        if (glog.size() == 3) begin
            chk("grant_seq0", glog[0], 2'b01);
            chk("grant_seq1", glog[1], 2'b10);
            chk("grant_seq2", glog[2], 2'b01);
        end

        // reset in the middle of a hung transfer
        @(negedge Hclk);
        hang = 1'b1; d_addr[0] = 32'h8000_0040; d_wr[0] = 1'b0;
        addr0 = d_addr[0]; write0 = 1'b0; req0 = 1'b1;
        repeat (4) @(negedge Hclk);
        chk("pre_reset_in_data", {Hreadyin, Htrans}, 3'b100);
        #2 Hreset = 1'b1;
        #1 chk("async_reset_outputs", any_out, 0);
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        hang = 1'b0; rd_k = 32'h7777_0001;
        d_addr[1] = 32'h8400_0300; d_wr[1] = 1'b0;
        addr1 = d_addr[1]; write1 = 1'b0; req1 = 1'b1;
        @(negedge Hclk);
        Hreset = 1'b0;
        push_exp(1'b0, 1'b0, 1'b1, rd_k, -1);
        push_exp(1'b1, 1'b0, 1'b1, rd_k, -1);
        wait_acks(2, 40);

        run(mk(1'b1, 32'h8800_0000, 1'b0, 32'h0, 32'h1357_9BDF, 2'b00, 1'b0, 1'b0, 1'b0, 4));

        repeat (3) @(negedge Hclk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
